ysyx_22050550_if_id_buf: RTL and testbench

YSYX_22050550_IF_ID_BUF -- requirements
Module: ysyx_22050550_if_id_buf

---
 rtl/ysyx_22050550_if_id_buf_pkg.sv | 5 +
 rtl/ysyx_22050550_pipe_slot.sv | 34 +++
 rtl/ysyx_22050550_if_id_buf.sv | 69 ++++++
 tb/tb_ysyx_22050550_if_id_buf.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_if_id_buf_pkg.sv
// ysyx_22050550_if_id_buf_pkg: shared bus widths for the IF/ID buffer (mode selected by YSYX_22050550_IFID_SKID_EN)
package ysyx_22050550_if_id_buf_pkg;
  localparam int ysyx_22050550_RegBus = 64;
  localparam int ysyx_22050550_InstBus = 32;
endpackage

// File: rtl/ysyx_22050550_pipe_slot.sv
// ysyx_22050550_pipe_slot: registered {valid, pc, inst} slot with load, clear and async active-low reset
module ysyx_22050550_pipe_slot
  import ysyx_22050550_if_id_buf_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load,
  input  logic                             clear,
  input  logic [ysyx_22050550_RegBus-1:0]  in_pc,
  input  logic [ysyx_22050550_InstBus-1:0] in_inst,
  output logic                             out_valid,
  output logic [ysyx_22050550_RegBus-1:0]  out_pc,
  output logic [ysyx_22050550_InstBus-1:0] out_inst
);
  logic                             r_valid;
  logic [ysyx_22050550_RegBus-1:0]  r_pc;
  logic [ysyx_22050550_InstBus-1:0] r_inst;
  // clear wins over load so a kill can never be overridden by a refill
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_inst  <= in_inst;
    end
  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign out_inst  = r_inst;
endmodule

// File: rtl/ysyx_22050550_if_id_buf.sv
// ysyx_22050550_if_id_buf: IF/ID pipeline buffer; define YSYX_22050550_IFID_SKID_EN for a 2-deep skid buffer, else 1-deep pass-through
module ysyx_22050550_if_id_buf
  import ysyx_22050550_if_id_buf_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [ysyx_22050550_RegBus-1:0]  in_pc,
  input  logic [ysyx_22050550_InstBus-1:0] in_inst,
  output logic                             in_ready,
  input  logic                             flush,
  output logic                             out_valid,
  output logic [ysyx_22050550_RegBus-1:0]  out_pc,
  output logic [ysyx_22050550_InstBus-1:0] out_inst,
  input  logic                             out_ready
);
  logic                             w_m_valid;
  logic                             w_acc;
  logic                             w_drain;
  logic                             w_m_load;
  logic                             w_m_clear;
  logic [ysyx_22050550_RegBus-1:0]  w_m_pc_d;
  logic [ysyx_22050550_InstBus-1:0] w_m_inst_d;
  assign out_valid = w_m_valid && !flush;
  assign w_acc     = in_valid && in_ready;
  assign w_drain   = out_valid && out_ready;
`ifdef YSYX_22050550_IFID_SKID_EN
  logic                             w_s_valid;
  logic                             w_s_load;
  logic                             w_s_clear;
  logic [ysyx_22050550_RegBus-1:0]  w_s_pc;
  logic [ysyx_22050550_InstBus-1:0] w_s_inst;
  // ready is a pure register output, cutting the out_ready -> in_ready path
  assign in_ready   = !w_s_valid;
  assign w_m_load   = !flush && (w_s_valid ? w_drain : w_acc && (!w_m_valid || w_drain));
  assign w_m_pc_d   = w_s_valid ? w_s_pc : in_pc;
  assign w_m_inst_d = w_s_valid ? w_s_inst : in_inst;
  assign w_s_load   = !flush && w_acc && w_m_valid && !w_drain;
  assign w_s_clear  = flush || (w_drain && w_s_valid);
  ysyx_22050550_pipe_slot u_s (
    .clock    (clock),
    .reset    (reset),
    .load     (w_s_load),
    .clear    (w_s_clear),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .out_valid(w_s_valid),
    .out_pc   (w_s_pc),
    .out_inst (w_s_inst)
  );
`else
  assign in_ready   = !w_m_valid || out_ready;
  assign w_m_load   = !flush && w_acc;
  assign w_m_pc_d   = in_pc;
  assign w_m_inst_d = in_inst;
`endif
  assign w_m_clear = flush || (w_drain && !w_m_load);
  ysyx_22050550_pipe_slot u_m (
    .clock    (clock),
    .reset    (reset),
    .load     (w_m_load),
    .clear    (w_m_clear),
    .in_pc    (w_m_pc_d),
    .in_inst  (w_m_inst_d),
    .out_valid(w_m_valid),
    .out_pc   (out_pc),
    .out_inst (out_inst)
  );
endmodule

// File: tb/tb_ysyx_22050550_if_id_buf.sv
// tb_ysyx_22050550_if_id_buf: random and directed stimulus checked against a FIFO-queue reference model
module tb_ysyx_22050550_if_id_buf;
`ifdef YSYX_22050550_IFID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready, out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        pin_en = 1'b0, pin_v = 1'b0;
  logic [63:0] pin_pc = '0;
  logic [31:0] pin_inst = '0;
  logic [95:0] q[$];
  int checks = 0, failures = 0;

  ysyx_22050550_if_id_buf dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  function automatic bit exp_rdy();
    return SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
  endfunction

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: the buffer is a FIFO of accepted entries, emptied by reset or flush
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset || flush) q.delete();
    else begin
      automatic bit acc = in_valid && exp_rdy();
      automatic bit drn = q.size() > 0 && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back({in_pc, in_inst});
    end
  end

  initial forever begin
    @(negedge clock);
    chk("out_valid", out_valid, q.size() > 0 && !flush);
    chk("in_ready", in_ready, exp_rdy());
    if (q.size() > 0 && !flush) begin
      chk("out_pc", out_pc, q[0][95:32]);
      chk("out_inst", out_inst, q[0][31:0]);
    end
    if (!reset) begin
      chk("reset_out_pc", out_pc, 0);
      chk("reset_out_inst", out_inst, 0);
    end
    if (pin_en) begin
      chk("pin_out_valid", out_valid, pin_v);
      if (pin_v) begin
        chk("pin_out_pc", out_pc, pin_pc);
        chk("pin_out_inst", out_inst, pin_inst);
        chk("pin_model_nonempty", q.size() > 0, 1);
        if (q.size() > 0) chk("pin_model_pc", q[0][95:32], pin_pc);
      end
    end
  end

  task automatic drive(bit v, logic [63:0] pc, logic [31:0] inst, bit ordy, bit fl,
                       bit pe = 0, bit pv = 0, logic [63:0] ppc = 0, logic [31:0] pinst = 0);
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    pin_en = pe; pin_v = pv; pin_pc = ppc; pin_inst = pinst;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) drive(1, 64'h1234, 32'h1, 1, 0, 1, 0);
    reset = 1'b1;
    drive(1, 64'h80000000, 32'h00100093, 1, 0, 1, 0);
    drive(1, 64'h80000004, 32'h00200113, 1, 0, 1, 1, 64'h80000000, 32'h00100093);
    drive(1, 64'h80000008, 32'h00300193, 1, 0, 1, 1, 64'h80000004, 32'h00200113);
    drive(0, 0, 0, 1, 0, 1, 1, 64'h80000008, 32'h00300193);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(1, 64'h80000000, 32'h00100093, 0, 0, 1, 0);
    drive(1, 64'h80000004, 32'h00200113, 0, 0, 1, 1, 64'h80000000, 32'h00100093);
    repeat (2) drive(!SKID, 64'h80000004, 32'h00200113, 0, 0, 1, 1, 64'h80000000, 32'h00100093);
    drive(!SKID, 64'h80000004, 32'h00200113, 1, 0, 1, 1, 64'h80000000, 32'h00100093);
    drive(0, 0, 0, 1, 0, 1, 1, 64'h80000004, 32'h00200113);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(1, 64'h80000008, 32'h00300193, 0, 0);
    drive(1, 64'h8000000c, 32'h00400213, 0, 0);
    drive(1, 64'h80000010, 32'h00500293, 1, 1, 1, 0);
    drive(1, 64'h90000000, 32'h00600313, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 1, 64'h90000000, 32'h00600313);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(1, 64'h80000100, 32'h00700393, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 64'h80000100, 32'h00700393);
    pin_en = 1'b1; pin_v = 1'b0;
    #2 reset = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    drive(1, 64'h80000200, 32'h00000013, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 1, 64'h80000200, 32'h00000013);
    repeat (10000)
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    repeat (4) drive(0, 0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
